adc_frame_ctrl: RTL and testbench
=================================

Name: adc_frame_ctrl

Overview:
- Upstream sequencer for the serial 12-bit, 8-channel ADC. Generates the chip-select, serial clock and address (DIN) bitstream for each 16-bit conversion frame, and paces frames with a programmable sample-rate timer.
- Scans a channel range and reports which channel's data the current frame carries.
- Its cs_adc/sclk outputs drive the ADC and the downstream capture stage, which assembles the 12-bit sample.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; must be ≥ 2.
- SAMPLE_PERIOD, 2500: clk cycles between frame-start ticks.
- FRAME_BITS, 16: SCLK cycles per frame.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run/stop; frames are issued only while high
- ch_first  in  3  first channel of scan range
- ch_last  in  3  last channel of scan range
- cs_adc  out  1  ADC chip select, active low
- sclk  out  1  ADC serial clock, idles high
- din_adc  out  1  address bitstream to ADC
- cur_ch  out  3  channel whose conversion data is shifting in the current frame
- frame_start  out  1  one-clk pulse when cs_adc falls
- frame_done  out  1  one-clk pulse when cs_adc rises
- overrun  out  1  sticky; set when a tick arrives during a busy frame

Behaviour:
- Reset values:
  - cs_adc=1, sclk=1, din_adc=0.
  - cur_ch=0, frame_start=0, frame_done=0, overrun=0.
  - Timer=0, state IDLE.
- Timer:
  - Counts 0..SAMPLE_PERIOD-1 while enable=1; it is held at 0 while enable=0.
  - Emits a tick at count 0, so the first tick falls on the first cycle enable is seen high.
- FSM states: IDLE, LEAD, SHIFT, TRAIL.
  - IDLE: on tick → LEAD. Drive cs_adc=0 and pulse frame_start. Latch ch_first/ch_last and compute next address.
  - LEAD: CLK_DIV cycles with sclk=1, so CS-to-first-falling-edge setup is one half-period.
  - SHIFT: 16 bits; each bit is CLK_DIV cycles sclk=0 followed by CLK_DIV cycles sclk=1.
    - din_adc updates only on the cycle sclk falls.
    - Bit index b=0..15. Bits 2,3,4 carry next_addr[2], [1], [0]; all other bits are 0.
  - TRAIL: CLK_DIV cycles with sclk=1. Then cs_adc=1, pulse frame_done → IDLE.
- Frame length: 34*CLK_DIV clk cycles from cs fall to cs rise.
- Channel sequencing:
  - The address sent in frame k selects the data in frame k+1.
  - cur_ch = the address sent in the previous frame. In the first frame after enable rises, cur_ch=0 (the ADC's power-up default channel).
  - next_addr advances ch_first..ch_last and wraps back to ch_first.
  - If ch_last < ch_first, scanning is fixed at ch_first.
  - A range change takes effect at the next frame start. The next address is clamped into the new range; out-of-range values restart at ch_first.
- Tick while state≠IDLE: the tick is dropped and overrun is set. overrun clears only on reset or on the enable 0→1 edge.
- enable falls mid-frame: the current frame completes normally, then the block stays in IDLE.
- Reset mid-frame: immediate return to reset values. cs_adc goes high asynchronously.
- All outputs are registered; no combinational paths from inputs to outputs.

Optional Feature:
- Macro: ADC_FRAME_CTRL_OVRCNT_EN.
- Defined:
  - Adds output ovr_count[7:0]: a saturating count of dropped ticks, saturating at 255.
  - Cleared with overrun.
- Undefined:
  - Port is absent; only the sticky overrun flag exists.

Decomposition:
- Shared package adc_pkg holds:
  - Constants ADC_FRAME_BITS=16, ADC_ADDR_W=3, ADC_DATA_W=12, ADC_ADDR_BIT_FIRST=2.
  - Enum adc_frame_state_t {IDLE, LEAD, SHIFT, TRAIL}.
- One sub-module, adc_rate_timer: the SAMPLE_PERIOD tick counter with enable and clear.

Test Plan:
- CLK_DIV=4, SAMPLE_PERIOD=200, ch_first=ch_last=5, enable=1.
  - cs_adc low for exactly 136 clks; 16 sclk falling edges.
  - din_adc pattern 0,0,1,0,1,0…0; frame_start period 200.
- Scan ch_first=1, ch_last=3, 5 frames.
  - Addresses sent: 1,2,3,1,2.
  - cur_ch: 0,1,2,3,1.
- SAMPLE_PERIOD=100 with CLK_DIV=4 (frame length 136).
  - overrun set on the first busy tick; frames never overlap; cs_adc high ≥ 1 clk between frames.
  - With the macro defined, ovr_count increments per dropped tick.
- enable deasserted at bit 7 of a frame.
  - Frame finishes with full 16 bits and frame_done pulses; no further frame_start.
- reset asserted mid-SHIFT.
  - cs_adc=1 and sclk=1 in the same cycle; after release with enable=1, the first frame has cur_ch=0.
- ch_last=2, ch_first=6.
  - Every frame sends address 6.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the serial ADC frame sequencer.
// Optional build macro ADC_FRAME_CTRL_OVRCNT_EN (used by adc_frame_ctrl)
// adds a saturating dropped-tick counter output.
package adc_pkg;

    localparam int ADC_FRAME_BITS     = 16;
    localparam int ADC_ADDR_W         = 3;
    localparam int ADC_DATA_W         = 12;
    localparam int ADC_ADDR_BIT_FIRST = 2;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL
    } adc_frame_state_t;

    // DIN level for frame bit b: the address occupies bits 2..4, MSB first.
    function automatic logic adc_din_bit(input logic [ADC_ADDR_W-1:0] addr, input int b);
        logic r;
        r = 1'b0;
        if (b >= ADC_ADDR_BIT_FIRST && b < ADC_ADDR_BIT_FIRST + ADC_ADDR_W)
            r = addr[2'(ADC_ADDR_W - 1 - (b - ADC_ADDR_BIT_FIRST))];
        return r;
    endfunction

endpackage

// File: rtl/adc_rate_timer.sv
// Sample-rate timer: counts 0..SAMPLE_PERIOD-1 while enabled and emits a
// tick whenever the count is 0, so the first tick lands on the first
// enabled cycle. Clear (or disable) parks the count at 0.
module adc_rate_timer #(
    parameter int SAMPLE_PERIOD = 2500
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    logic [TW-1:0] count;

    // Period counter; restarts from 0 whenever the timer is stopped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr || !en) begin
            count <= '0;
        end else if (count == TW'(SAMPLE_PERIOD - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = en & ~clr & (count == '0);

endmodule

// File: rtl/adc_frame_ctrl.sv
// Frame sequencer for the serial 12-bit, 8-channel ADC: generates CS, SCLK
// and the DIN address stream, paces frames from the sample-rate timer and
// scans the channel range ch_first..ch_last.
// Optional build macro ADC_FRAME_CTRL_OVRCNT_EN adds ovr_count[7:0].
//
// state | meaning
// IDLE  | cs high, waiting for a timer tick
// LEAD  | cs low, sclk high for one half-period (CS setup)
// SHIFT | 16 sclk cycles, din changes on each falling edge
// TRAIL | sclk high for one half-period before cs rises
module adc_frame_ctrl
    import adc_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 2500,
    parameter int FRAME_BITS    = ADC_FRAME_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADC_ADDR_W-1:0] ch_first,
    input  logic [ADC_ADDR_W-1:0] ch_last,
    output logic                  cs_adc,
    output logic                  sclk,
    output logic                  din_adc,
    output logic [ADC_ADDR_W-1:0] cur_ch,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic                  overrun
`ifdef ADC_FRAME_CTRL_OVRCNT_EN
    ,
    output logic [7:0]            ovr_count
`endif
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(FRAME_BITS);

    adc_frame_state_t      state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_idx;
    logic                  tick;
    logic                  en_q;
    logic                  en_rise;
    logic                  first_pending;
    logic [ADC_ADDR_W-1:0] addr_tx;
    logic [ADC_ADDR_W-1:0] nxt_ptr;
    logic [ADC_ADDR_W-1:0] send_addr;
    logic [ADC_ADDR_W-1:0] nxt_after;

    adc_rate_timer #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .en   (enable),
        .clr  (~enable),
        .tick (tick)
    );

    assign en_rise = enable & ~en_q;

    // Address for the frame about to start, clamped into the live range,
    // and the scan pointer for the frame after it.
    always_comb begin
        send_addr = ch_first;
        nxt_after = ch_first;
        if (ch_last >= ch_first) begin
            if (nxt_ptr >= ch_first && nxt_ptr <= ch_last)
                send_addr = nxt_ptr;
            if (send_addr != ch_last)
                nxt_after = send_addr + 1'b1;
        end
    end

`ifdef ADC_FRAME_CTRL_OVRCNT_EN
    logic [7:0] ovr_base;

    // An enable rising edge clears the count in the same cycle a drop may land.
    always_comb begin
        ovr_base = en_rise ? 8'd0 : ovr_count;
    end
`endif

    // Frame sequencer with registered outputs, overrun tracking and scan state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            cs_adc        <= 1'b1;
            sclk          <= 1'b1;
            din_adc       <= 1'b0;
            cur_ch        <= '0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
            overrun       <= 1'b0;
            en_q          <= 1'b0;
            first_pending <= 1'b1;
            addr_tx       <= '0;
            nxt_ptr       <= '0;
`ifdef ADC_FRAME_CTRL_OVRCNT_EN
            ovr_count     <= '0;
`endif
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            en_q        <= enable;

            if (en_rise) begin
                overrun       <= 1'b0;
                first_pending <= 1'b1;
`ifdef ADC_FRAME_CTRL_OVRCNT_EN
                ovr_count     <= '0;
`endif
            end

            // A tick while busy is dropped; a set in the same cycle as the
            // enable-edge clear wins so that drop is not lost.
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
`ifdef ADC_FRAME_CTRL_OVRCNT_EN
                ovr_count <= (ovr_base == 8'hFF) ? ovr_base : ovr_base + 8'd1;
`endif
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        state         <= LEAD;
                        cs_adc        <= 1'b0;
                        frame_start   <= 1'b1;
                        cnt           <= CW'(CLK_DIV - 1);
                        cur_ch        <= (first_pending || en_rise) ? '0 : addr_tx;
                        first_pending <= 1'b0;
                        addr_tx       <= send_addr;
                        nxt_ptr       <= nxt_after;
                    end
                end
                LEAD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state   <= SHIFT;
                        cnt     <= CW'(CLK_DIV - 1);
                        sclk    <= 1'b0;
                        bit_idx <= '0;
                        din_adc <= adc_din_bit(addr_tx, 0);
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt <= CW'(CLK_DIV - 1);
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else if (bit_idx == BW'(FRAME_BITS - 1)) begin
                            state <= TRAIL;
                        end else begin
                            sclk    <= 1'b0;
                            bit_idx <= bit_idx + 1'b1;
                            din_adc <= adc_din_bit(addr_tx, int'(bit_idx) + 1);
                        end
                    end
                end
                TRAIL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state      <= IDLE;
                        cs_adc     <= 1'b1;
                        frame_done <= 1'b1;
                        din_adc    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_ctrl.sv
// Scoreboard bench for adc_frame_ctrl (CLK_DIV=4, SAMPLE_PERIOD=100).
// A per-cycle reference model predicts every accepted frame (start cycle,
// address, cur_ch, overrun) and queues it; a monitor pops and checks on
// each frame_start and checks frame shape on frame_done.
module tb_adc_frame_ctrl;

    localparam int CLK_DIV   = 4;
    localparam int PERIOD    = 100;
    localparam int FRAME_LEN = 34 * CLK_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] ch_first = 3'd0;
    logic [2:0] ch_last = 3'd0;
    logic       cs_adc, sclk, din_adc, frame_start, frame_done, overrun;
    logic [2:0] cur_ch;
`ifdef ADC_FRAME_CTRL_OVRCNT_EN
    logic [7:0] ovr_count;
`endif

    adc_frame_ctrl #(
        .CLK_DIV(CLK_DIV),
        .SAMPLE_PERIOD(PERIOD),
        .FRAME_BITS(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .ch_first(ch_first),
        .ch_last(ch_last),
        .cs_adc(cs_adc),
        .sclk(sclk),
        .din_adc(din_adc),
        .cur_ch(cur_ch),
        .frame_start(frame_start),
        .frame_done(frame_done),
        .overrun(overrun)
`ifdef ADC_FRAME_CTRL_OVRCNT_EN
        ,
        .ovr_count(ovr_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        int cyc;
        int addr;
        int cur;
        int ovr;
        int ocnt;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- reference model (evaluated at every clk edge) ----------
    int cyc = 0;
    int m_prev_en = 0;
    int m_rise_cyc = 0;
    int m_busy_until = 0;
    int m_ovr = 0;
    int m_ocnt = 0;
    int m_scan = 0;
    int m_first = 1;
    int m_last_sent = 0;

    always @(posedge clk) begin
        int f, l, send;
        exp_t e;
        cyc++;
        if (reset) begin
            m_prev_en = 0; m_busy_until = 0; m_ovr = 0; m_ocnt = 0;
            m_scan = 0; m_first = 1; m_last_sent = 0;
        end else begin
            if (enable && !m_prev_en) begin
                m_rise_cyc = cyc; m_ovr = 0; m_ocnt = 0; m_first = 1;
            end
            if (enable && ((cyc - m_rise_cyc) % PERIOD == 0)) begin
                if (cyc >= m_busy_until) begin
                    f = int'(ch_first); l = int'(ch_last);
                    if (l < f) send = f;
                    else if (m_scan >= f && m_scan <= l) send = m_scan;
                    else send = f;
                    m_scan = (l >= f && send < l) ? send + 1 : f;
                    e.cyc = cyc; e.addr = send; e.ovr = m_ovr; e.ocnt = m_ocnt;
                    e.cur = m_first ? 0 : m_last_sent;
                    m_first = 0; m_last_sent = send;
                    m_busy_until = cyc + FRAME_LEN + 1;
                    exp_q.push_back(e);
                end else begin
                    m_ovr = 1;
                    if (m_ocnt < 255) m_ocnt++;
                end
            end
            m_prev_en = enable ? 1 : 0;
        end
    end

    // ---------------- monitor -----------------------------------------------
    int in_frame = 0, f_len = 0, f_falls = 0, f_cycles = 0, f_addr = 0;
    int last_done = -1000;
    int n_starts = 0, n_dones = 0;
    logic [15:0] f_bits;
    logic prev_sclk = 1'b1;
    int obs_addr[$];
    int obs_cur[$];

    always @(negedge clk) begin
        exp_t e;
        logic [15:0] pat;
        if (reset) begin
            in_frame = 0;
            prev_sclk = 1'b1;
        end else begin
            if (frame_start) begin
                n_starts++;
                check("no_overlap", in_frame, 0);
                check("cs_gap", int'(cyc > last_done), 1);
                check("sb_nonempty", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("start_cyc", cyc, e.cyc);
                    check("cur_ch", int'(cur_ch), e.cur);
                    check("overrun", int'(overrun), e.ovr);
`ifdef ADC_FRAME_CTRL_OVRCNT_EN
                    check("ovr_count", int'(ovr_count), e.ocnt);
`endif
                    f_addr = e.addr;
                end
                obs_cur.push_back(int'(cur_ch));
                in_frame = 1; f_len = 0; f_falls = 0; f_cycles = 0; f_bits = '0;
            end
            if (in_frame != 0) begin
                f_cycles++;
                if (!cs_adc) f_len++;
                if (prev_sclk && !sclk) begin
                    if (f_falls < 16) f_bits[f_falls] = din_adc;
                    f_falls++;
                end
                if (frame_done) begin
                    n_dones++;
                    pat = '0;
                    pat[2] = f_addr[2]; pat[3] = f_addr[1]; pat[4] = f_addr[0];
                    check("cs_high_at_done", int'(cs_adc), 1);
                    check("frame_len", f_len, FRAME_LEN);
                    check("sclk_falls", f_falls, 16);
                    check("din_pattern", int'(f_bits), int'(pat));
                    obs_addr.push_back(int'({f_bits[2], f_bits[3], f_bits[4]}));
                    in_frame = 0;
                    last_done = cyc;
                end else if (f_cycles > 300) begin
                    check("frame_timeout", f_cycles, FRAME_LEN);
                    in_frame = 0;
                end
            end
            prev_sclk = sclk;
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < budget);
        check("wait_frame_start", int'(frame_start), 1);
    endtask

    task automatic wait_falls(input int k, input int budget);
        int n = 0, seen = 0;
        logic p;
        p = sclk;
        while (seen < k && n < budget) begin
            @(negedge clk);
            n++;
            if (p && !sclk) seen++;
            p = sclk;
        end
        check("wait_sclk_falls", seen, k);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int scan_addr_exp[5] = '{1, 2, 3, 1, 2};
    int scan_cur_exp[5]  = '{0, 1, 2, 3, 1};

    initial begin
        int s0, d0;
        step(4);
        check("rst_cs", int'(cs_adc), 1);
        check("rst_sclk", int'(sclk), 1);
        check("rst_din", int'(din_adc), 0);
        check("rst_cur_ch", int'(cur_ch), 0);
        check("rst_fstart", int'(frame_start), 0);
        check("rst_fdone", int'(frame_done), 0);
        check("rst_overrun", int'(overrun), 0);

        // Fixed channel 5, overrun from the busy tick at +100.
        ch_first = 3'd5; ch_last = 3'd5;
        reset = 1'b0;
        enable = 1'b1;
        wait_start(10);
        step(60);
        check("ovr_before_busy_tick", int'(overrun), 0);
        step(50);
        check("ovr_after_busy_tick", int'(overrun), 1);
        step(600);

        // Scan 1..3 from a fresh reset.
        @(negedge clk); #2 reset = 1'b1;
        step(2);
        ch_first = 3'd1; ch_last = 3'd3;
        obs_addr.delete(); obs_cur.delete();
        reset = 1'b0;
        step(1000);
        check("scan_frames", int'(obs_addr.size() >= 5), 1);
        if (obs_addr.size() >= 5 && obs_cur.size() >= 5)
            for (int i = 0; i < 5; i++) begin
                check("scan_addr", obs_addr[i], scan_addr_exp[i]);
                check("scan_cur", obs_cur[i], scan_cur_exp[i]);
            end

        // Drop enable at bit 7: frame completes, nothing follows.
        wait_start(300);
        wait_falls(8, 200);
        enable = 1'b0;
        s0 = n_starts; d0 = n_dones;
        step(400);
        check("no_start_after_disable", n_starts - s0, 0);
        check("done_after_disable", n_dones - d0, 1);

        // Inverted range: every frame sends ch_first.
        obs_addr.delete();
        ch_first = 3'd6; ch_last = 3'd2;
        enable = 1'b1;
        step(650);
        enable = 1'b0;
        step(200);
        check("fixed_frames", int'(obs_addr.size() >= 3), 1);
        foreach (obs_addr[i]) check("fixed_addr", obs_addr[i], 6);

        // Reset in the middle of SHIFT.
        ch_first = 3'd2; ch_last = 3'd4;
        enable = 1'b1;
        wait_start(20);
        wait_falls(5, 200);
        @(posedge clk); #2 reset = 1'b1;
        #1;
        check("midrst_cs", int'(cs_adc), 1);
        check("midrst_sclk", int'(sclk), 1);
        step(3);
        reset = 1'b0;
        step(500);

        // Randomized segments: ranges, enable toggles, occasional reset.
        for (int it = 0; it < 30; it++) begin
            ch_first = 3'($urandom_range(0, 7));
            ch_last  = 3'($urandom_range(0, 7));
            enable   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk); #2 reset = 1'b1;
                step(2);
                reset = 1'b0;
            end
            step($urandom_range(30, 500));
        end

        enable = 1'b0;
        step(300);
        check("sb_empty", exp_q.size(), 0);
        check("frames_seen", int'(n_starts >= 20), 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
